// File: rtl/p_subtractor_seq_if.sv
// Handshake bundle for the digit-serial subtractor: operand side, result side and busy.
// The master drives operands and out_ready; the slave (the subtractor) drives the rest.
interface p_subtractor_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );
endinterface

// File: rtl/p_subtractor_seq.sv
// Digit-serial unsigned subtractor: d = a - b - bin, computed as a + ~b + ~bin,
// DIGIT bits per cycle LSB-first, with valid/ready on both sides.
module p_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               rst,
  p_subtractor_seq_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("p_subtractor_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;   // holds ~b
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bout_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;

  // One digit of a + ~b + carry; sum bits enter the result at its MSB end.
  assign digit_sum = {1'b0, a_sh_reg[DIGIT-1:0]}
                   + {1'b0, b_sh_reg[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_reg};
  assign res_next  = (res_reg >> DIGIT)
                   | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg == DONE);
    bus.busy      = (state_reg != IDLE);
  end

  assign bus.d    = d_reg;
  assign bus.bout = bout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      d_reg     <= '0;
      bout_reg  <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= ~bus.b;
            carry_reg <= ~bus.bin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sh_reg  <= a_sh_reg >> DIGIT;
          b_sh_reg  <= b_sh_reg >> DIGIT;
          res_reg   <= res_next;
          carry_reg <= digit_sum[DIGIT];
          cnt_reg   <= cnt_reg + 1'b1;
          // Publish only on the last digit so d/bout stay stable between ops.
          if (cnt_reg == LAST) begin
            d_reg    <= res_next;
            bout_reg <= ~digit_sum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_p_subtractor_seq.sv
// Self-checking bench for p_subtractor_seq: a countdown-based transaction model
// checked every cycle, directed literal cases, then randomized traffic.
module tb_p_subtractor_seq;
  localparam int W = 32;
  localparam int D = 4;
  localparam int NDIG = W / D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  p_subtractor_seq_if #(.WIDTH(W)) sif ();

  p_subtractor_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model state: idle flag, cycles left until result, result visible flag.
  logic         m_idle, m_done, m_bout, m_pb;
  logic [W-1:0] m_d, m_pd;
  int           m_left;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
      m_d    <= '0;
      m_bout <= 1'b0;
    end else if (m_idle) begin
      if (sif.in_valid) begin
        {m_pb, m_pd} <= ref_sub(sif.a, sif.b, sif.bin);
        m_left <= NDIG;
        m_idle <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_d    <= m_pd;
        m_bout <= m_pb;
      end
    end else if (m_done && sif.out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(sif.in_ready), 64'(m_idle));
      chk("out_valid", 64'(sif.out_valid), 64'(m_done));
      chk("busy", 64'(sif.busy), 64'(!m_idle));
      chk("d", 64'(sif.d), 64'(m_d));
      chk("bout", 64'(sif.bout), 64'(m_bout));
      if (sif.out_valid && sif.out_ready && !rst)
        $display("xfer d=%h bout=%0d", sif.d, sif.bout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic mut, output int lat);
    int n;
    n = 0;
    while (!sif.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!sif.in_ready) chk("accept_timeout", 64'(sif.in_ready), 64'd1);
    sif.in_valid = 1'b1;
    sif.a = ia;
    sif.b = ib;
    sif.bin = ibin;
    step();
    sif.in_valid = 1'b0;
    lat = 0;
    while (!sif.out_valid && lat < 100) begin
      if (mut) begin
        sif.a = $urandom;
        sif.b = $urandom;
        sif.bin = 1'($urandom);
      end
      step();
      lat++;
    end
    $display("op a=%h b=%h bin=%0d lat=%0d d=%h bout=%0d", ia, ib, ibin, lat, sif.d, sif.bout);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    logic [W-1:0] hold_d;
    logic hold_b;

    rst = 1'b1;
    sif.in_valid = 1'b1;
    sif.a = 32'h1234_5678;
    sif.b = 32'h0000_0001;
    sif.bin = 1'b0;
    sif.out_ready = 1'b1;

    // Reset held two cycles with in_valid high: nothing may be accepted.
    step();
    chk_en = 1'b1;
    chk("rst_in_ready", 64'(sif.in_ready), 64'd1);
    chk("rst_busy", 64'(sif.busy), 64'd0);
    step();
    chk("rst_d", 64'(sif.d), 64'd0);
    rst = 1'b0;
    sif.in_valid = 1'b0;
    step();

    run_op(32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("basic_lat", 64'(lat), 64'd8);
    chk("basic_d", 64'(sif.d), 64'h0000_0001);
    chk("basic_bout", 64'(sif.bout), 64'd0);
    step();
    chk("basic_pulse", 64'(sif.out_valid), 64'd0);

    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("uf1_d", 64'(sif.d), 64'hFFFF_FFFF);
    chk("uf1_bout", 64'(sif.bout), 64'd1);
    step();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    chk("uf2_d", 64'(sif.d), 64'hFFFF_FFFF);
    chk("uf2_bout", 64'(sif.bout), 64'd1);
    step();

    // Operands scrambled during RUN must not affect the result.
    run_op(32'h1010_1010, 32'h0011_0101, 1'b1, 1'b1, lat);
    chk("bin_d", 64'(sif.d), 64'h0FFF_0F0E);
    chk("bin_bout", 64'(sif.bout), 64'd0);
    chk("bin_lat", 64'(lat), 64'd8);
    step();

    // Backpressure with in_valid pulses that must be ignored.
    sif.out_ready = 1'b0;
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, lat);
    hold_d = sif.d;
    hold_b = sif.bout;
    chk("bp_d0", 64'(hold_d), 64'h0000_00FF);
    for (int i = 0; i < 5; i++) begin
      sif.in_valid = 1'b1;
      sif.a = 32'h5;
      sif.b = 32'h3;
      sif.bin = 1'b0;
      chk("bp_in_ready", 64'(sif.in_ready), 64'd0);
      step();
      chk("bp_valid", 64'(sif.out_valid), 64'd1);
      chk("bp_d_hold", 64'(sif.d), 64'(hold_d));
      chk("bp_bout_hold", 64'(sif.bout), 64'(hold_b));
    end
    sif.in_valid = 1'b0;
    sif.out_ready = 1'b1;
    step();
    chk("bp_release", 64'(sif.in_ready), 64'd1);
    run_op(32'h5, 32'h3, 1'b0, 1'b0, lat);
    chk("bp_next_d", 64'(sif.d), 64'h2);
    step();

    // Reset lands on the third RUN edge; the aborted op never surfaces.
    sif.in_valid = 1'b1;
    sif.a = 32'h10;
    sif.b = 32'h1;
    sif.bin = 1'b0;
    step();
    sif.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_idle", 64'(sif.in_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_rst_no_valid", 64'(sif.out_valid), 64'd0);
    end
    run_op(32'h10, 32'h1, 1'b0, 1'b0, lat);
    chk("mid_rst_d", 64'(sif.d), 64'h0000_000F);
    chk("mid_rst_bout", 64'(sif.bout), 64'd0);
    chk("mid_rst_lat", 64'(lat), 64'd8);
    step();

    // Randomized traffic with sparse resets; the per-cycle compare does the work.
    for (int i = 0; i < 1500; i++) begin
      sif.in_valid = 1'($urandom);
      sif.a = pick();
      sif.b = pick();
      sif.bin = 1'($urandom);
      sif.out_ready = (($urandom % 4) != 0);
      rst = (($urandom % 300) == 0);
      step();
    end
    rst = 1'b0;
    sif.in_valid = 1'b0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/p_subtractor_seq.md
Name: p_subtractor_seq

Overview:
Multi-cycle unsigned subtractor, the inverse-direction companion to the combinational p_adder: computes d = a - b - bin and a borrow-out. It processes operands digit-serially, DIGIT bits per cycle LSB-first, to trade latency for area. It uses valid/ready handshakes on both input and output so it can sit between pipeline stages of the arithmetic datapath.

Parameters:
WIDTH, 32, operand/result width in bits
DIGIT, 4, bits processed per RUN cycle; WIDTH % DIGIT must be 0, otherwise elaboration error ($error)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b/bin valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  d/bout valid
out_ready  input  1  downstream accepts result
d  output  WIDTH  difference, modulo 2^WIDTH
bout  output  1  borrow-out; 1 iff a < b + bin, unsigned
busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, d=0, bout=0, internal shift regs/counter=0. Reset has priority over every other event, including mid-RUN and DONE; any in-flight result is discarded, and no out_valid is produced for it.
- Arithmetic: d = a + ~b + ~bin evaluated serially. Carry register is initialised to ~bin on accept. Each RUN cycle adds DIGIT LSBs of the a-shift and ~b-shift registers plus the carry, writes the DIGIT sum bits into the result register MSB end (shift right), and updates the carry. After the final digit, bout = ~carry.
- States:
  - IDLE: in_ready=1. Accept when in_valid && in_ready. Latch a, ~b, carry=~bin, cnt=0 -> RUN. in_valid=0 -> stay.
  - RUN: in_ready=0, busy=1. One digit per cycle, cnt++. When cnt == WIDTH/DIGIT-1 is processed -> DONE, with d/bout registered final at the same edge.
  - DONE: out_valid=1, busy=1, d/bout stable. out_ready=1 -> IDLE on the next edge (out_valid=0). out_ready=0 -> hold indefinitely.
- Latency: out_valid rises exactly WIDTH/DIGIT cycles after the accept edge (8 cycles with defaults). Throughput is one op per WIDTH/DIGIT+2 cycles minimum.
- in_valid while in_ready=0: ignored, with no side effect on operands being processed.
- Operand inputs are sampled only on the accept edge; later changes to a/b/bin do not affect the result.
- d/bout change only on the final RUN edge or on reset. They hold their last value in IDLE.
- DONE with out_ready=1 and in_valid=1 together: result handed off, return to IDLE; the new operand is not accepted that cycle (in_ready=0 in DONE).
- Wrap-around: d is modulo 2^WIDTH. bout=1 whenever the true result is negative.

Test Plan:
- Reset check: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, d=0, bout=0, busy=0 throughout; no accept occurs during reset.
- Basic: a=0x00000002, b=0x00000001, bin=0, out_ready=1 -> out_valid exactly 8 cycles after accept, d=0x00000001, bout=0, one-cycle out_valid pulse.
- Underflow: a=0x00000000, b=0x00000001, bin=0 -> d=0xFFFFFFFF, bout=1. Then a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1 -> d=0xFFFFFFFF, bout=1.
- Borrow-in: a=0x10101010, b=0x00110101, bin=1 -> d=0x0FFF0F0E, bout=0. Change a/b mid-RUN -> result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> d/bout/out_valid stable, in_ready=0. Pulse in_valid with a=0x5, b=0x3 during that window -> not accepted. Raise out_ready -> IDLE next cycle, and the following op computes correctly.
- Reset mid-op: accept a=0x00000010, b=0x00000001, assert rst on 3rd RUN cycle -> IDLE next edge, out_valid never asserts. Next op a=0x00000010, b=0x00000001 -> d=0x0000000F, bout=0, 8-cycle latency.
